// File: rtl/wb_arbiter.sv
// Writeback arbiter: two small in-order queues (ALU, LSU) tagged with a
// shared 3-bit sequence number, drained one entry per cycle in global
// acceptance order into a registered register-file write port.

// One source queue: DEPTH entries of {addr, data, seq}, count-based full/empty.
module wb_arbiter_fifo #(
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int DEPTH = 2,
    parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] data_i,
    input  logic [2:0]    seq_i,
    input  logic [AW-1:0] query_i,
    output logic [CW-1:0] cnt_o,
    output logic [AW-1:0] head_addr_o,
    output logic [DW-1:0] head_data_o,
    output logic [2:0]    head_seq_o,
    output logic          match_o
);
    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [2:0]    seq_q  [DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pointer and occupancy next-state; the top never pushes full or pops empty.
    always_comb begin
        rd_d  = pop_i  ? ptr_inc(rd_q) : rd_q;
        wr_d  = push_i ? ptr_inc(wr_q) : wr_q;
        cnt_d = cnt_q;
        if (push_i && !pop_i)      cnt_d = cnt_q + 1'b1;
        else if (!push_i && pop_i) cnt_d = cnt_q - 1'b1;
    end

    // Entry storage and pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                seq_q[i]  <= '0;
            end
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            if (push_i) begin
                addr_q[wr_q] <= addr_i;
                data_q[wr_q] <= data_i;
                seq_q[wr_q]  <= seq_i;
            end
        end
    end

    assign cnt_o       = cnt_q;
    assign head_addr_o = addr_q[rd_q];
    assign head_data_o = data_q[rd_q];
    assign head_seq_o  = seq_q[rd_q];

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        match_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((((i - int'(rd_q)) + DEPTH) % DEPTH) < int'(cnt_q) && addr_q[i] == query_i)
                match_o = 1'b1;
        end
    end
endmodule

module wb_arbiter #(
    parameter int REG_ADDR_LEN = 5,
    parameter int REG_LEN      = 32,
    parameter int DEPTH        = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    alu_valid,
    input  logic [REG_ADDR_LEN-1:0] alu_addr,
    input  logic [REG_LEN-1:0]      alu_data,
    output logic                    alu_ready,
    input  logic                    lsu_valid,
    input  logic [REG_ADDR_LEN-1:0] lsu_addr,
    input  logic [REG_LEN-1:0]      lsu_data,
    output logic                    lsu_ready,
    output logic                    wr_en,
    output logic [REG_ADDR_LEN-1:0] wr_addr,
    output logic [REG_LEN-1:0]      wr_data,
    input  logic [REG_ADDR_LEN-1:0] query_addr,
    output logic                    query_busy
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]           alu_cnt, lsu_cnt;
    logic [REG_ADDR_LEN-1:0] alu_h_addr, lsu_h_addr;
    logic [REG_LEN-1:0]      alu_h_data, lsu_h_data;
    logic [2:0]              alu_h_seq, lsu_h_seq, seq_diff;
    logic                    alu_match, lsu_match;
    logic                    alu_push, lsu_push, alu_pop, lsu_pop, alu_older;
    logic [2:0]              seq_q, seq_d, alu_seq;
    logic                    wr_en_q, wr_en_d;
    logic [REG_ADDR_LEN-1:0] wr_addr_q, wr_addr_d;
    logic [REG_LEN-1:0]      wr_data_q, wr_data_d;

    // Acceptance uses registered counts only; x0 writes are accepted but dropped.
    assign alu_ready = rst & rdy & (alu_cnt < CW'(DEPTH));
    assign lsu_ready = rst & rdy & (lsu_cnt < CW'(DEPTH));
    assign alu_push  = alu_valid & alu_ready & (alu_addr != '0);
    assign lsu_push  = lsu_valid & lsu_ready & (lsu_addr != '0);

    // Same-cycle pushes: LSU takes the current tag, ALU the next one.
    assign alu_seq = lsu_push ? seq_q + 3'd1 : seq_q;
    assign seq_d   = seq_q + {2'b00, alu_push} + {2'b00, lsu_push};

    // With at most four entries in flight, the older head is within 1..3 tags.
    assign seq_diff  = lsu_h_seq - alu_h_seq;
    assign alu_older = (seq_diff != 3'd0) && (seq_diff <= 3'd3);
    assign alu_pop   = rdy & (alu_cnt != '0) & ((lsu_cnt == '0) | alu_older);
    assign lsu_pop   = rdy & (lsu_cnt != '0) & ~alu_pop;

    wb_arbiter_fifo #(.AW(REG_ADDR_LEN), .DW(REG_LEN), .DEPTH(DEPTH)) u_alu_q (
        .clk(clk), .rst(rst), .push_i(alu_push), .pop_i(alu_pop),
        .addr_i(alu_addr), .data_i(alu_data), .seq_i(alu_seq), .query_i(query_addr),
        .cnt_o(alu_cnt), .head_addr_o(alu_h_addr), .head_data_o(alu_h_data),
        .head_seq_o(alu_h_seq), .match_o(alu_match)
    );

    wb_arbiter_fifo #(.AW(REG_ADDR_LEN), .DW(REG_LEN), .DEPTH(DEPTH)) u_lsu_q (
        .clk(clk), .rst(rst), .push_i(lsu_push), .pop_i(lsu_pop),
        .addr_i(lsu_addr), .data_i(lsu_data), .seq_i(seq_q), .query_i(query_addr),
        .cnt_o(lsu_cnt), .head_addr_o(lsu_h_addr), .head_data_o(lsu_h_data),
        .head_seq_o(lsu_h_seq), .match_o(lsu_match)
    );

    // Write port next-state: everything holds while rdy is low.
    always_comb begin
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (rdy) begin
            wr_en_d = alu_pop | lsu_pop;
            if (alu_pop) begin
                wr_addr_d = alu_h_addr;
                wr_data_d = alu_h_data;
            end else if (lsu_pop) begin
                wr_addr_d = lsu_h_addr;
                wr_data_d = lsu_h_data;
            end
        end
    end

    // Sequence counter and registered write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            seq_q     <= seq_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

    assign query_busy = (query_addr != '0) &
                        (alu_match | lsu_match | (wr_en_q & (wr_addr_q == query_addr)));
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with an in-order scoreboard of pending writes.
module tb_wb_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0, rst = 1'b0, rdy = 1'b0;
    logic          alu_valid = 1'b0, lsu_valid = 1'b0;
    logic [AW-1:0] alu_addr = '0, lsu_addr = '0, query_addr = '0;
    logic [DW-1:0] alu_data = '0, lsu_data = '0;
    logic          alu_ready, lsu_ready, wr_en, query_busy;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    wb_arbiter #(.REG_ADDR_LEN(AW), .REG_LEN(DW), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_addr(lsu_addr), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .query_addr(query_addr), .query_busy(query_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          src;   // 1 = ALU, 0 = LSU
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          pend_q[$];
    int            m_alu_cnt = 0, m_lsu_cnt = 0;
    logic          m_wr_en = 1'b0;
    logic [AW-1:0] m_wr_addr = '0;
    logic [DW-1:0] m_wr_data = '0;
    int            checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_busy(input logic [AW-1:0] a);
        if (a == '0) return 1'b0;
        if (m_wr_en && m_wr_addr == a) return 1'b1;
        foreach (pend_q[i]) if (pend_q[i].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: drive, check readiness/hazard, advance, update model, check write port.
    task automatic step(input logic r,
                        input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                        input logic [AW-1:0] qa);
        logic exp_ar, exp_lr;
        ent_t e;
        rdy = r; alu_valid = av; alu_addr = aa; alu_data = ad;
        lsu_valid = lv; lsu_addr = la; lsu_data = ld; query_addr = qa;
        #1;
        exp_ar = r && (m_alu_cnt < 2);
        exp_lr = r && (m_lsu_cnt < 2);
        chk("alu_ready", {63'd0, alu_ready}, {63'd0, exp_ar});
        chk("lsu_ready", {63'd0, lsu_ready}, {63'd0, exp_lr});
        chk("query_busy", {63'd0, query_busy}, {63'd0, model_busy(qa)});
        @(posedge clk);
        #1;
        if (r) begin
            if (pend_q.size() > 0) begin
                e = pend_q.pop_front();
                if (e.src) m_alu_cnt--; else m_lsu_cnt--;
                m_wr_en = 1'b1; m_wr_addr = e.addr; m_wr_data = e.data;
            end else begin
                m_wr_en = 1'b0;
            end
            if (lv && exp_lr && la != '0) begin
                pend_q.push_back(ent_t'{1'b0, la, ld});
                m_lsu_cnt++;
            end
            if (av && exp_ar && aa != '0) begin
                pend_q.push_back(ent_t'{1'b1, aa, ad});
                m_alu_cnt++;
            end
        end
        chk("wr_en", {63'd0, wr_en}, {63'd0, m_wr_en});
        chk("wr_addr", {59'd0, wr_addr}, {59'd0, m_wr_addr});
        chk("wr_data", {32'd0, wr_data}, {32'd0, m_wr_data});
    endtask

    task automatic idle(input int n, input logic [AW-1:0] qa);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, qa);
    endtask

    // Asynchronous reset applied between edges; outputs must clear immediately.
    task automatic do_reset();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
        chk("rst_wr_addr", {59'd0, wr_addr}, 64'd0);
        chk("rst_wr_data", {32'd0, wr_data}, 64'd0);
        chk("rst_alu_ready", {63'd0, alu_ready}, 64'd0);
        chk("rst_lsu_ready", {63'd0, lsu_ready}, 64'd0);
        pend_q.delete();
        m_alu_cnt = 0; m_lsu_cnt = 0;
        m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rdy = 1'b1;
        #2;
        chk("init_wr_en", {63'd0, wr_en}, 64'd0);
        chk("init_alu_ready", {63'd0, alu_ready}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Single ALU write, hazard visible while queued and while on the port
        step(1'b1, 1'b1, 5'd5, 32'h11, 1'b0, '0, '0, 5'd5);
        idle(4, 5'd5);

        // Same-cycle pushes to the same register: LSU first
        step(1'b1, 1'b1, 5'd3, 32'hBB, 1'b1, 5'd3, 32'hAA, 5'd3);
        idle(4, 5'd3);

        // ALU alone for four cycles
        for (int i = 1; i <= 4; i++)
            step(1'b1, 1'b1, AW'(i), DW'(32'h100 + i), 1'b0, '0, '0, 5'd2);
        idle(3, 5'd4);

        // Both sources saturating: queues fill, readiness drops
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b1, AW'(8 + i), DW'(32'hA000 + i),
                 1'b1, AW'(20 + i), DW'(32'hB000 + i), AW'(20 + i));
        idle(7, 5'd25);

        // x0 is accepted and dropped
        step(1'b1, 1'b1, 5'd0, 32'hFF, 1'b0, '0, '0, 5'd0);
        idle(3, 5'd0);

        // Stall with two entries queued, requests held high during stall
        step(1'b1, 1'b1, 5'd7, 32'h77, 1'b1, 5'd9, 32'h99, 5'd7);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 5'd12, 32'hCC, 1'b1, 5'd13, 32'hDD, 5'd7);
        idle(4, 5'd9);

        // Reset with three writes pending
        step(1'b1, 1'b1, 5'd10, 32'h1010, 1'b1, 5'd11, 32'h1111, 5'd11);
        step(1'b1, 1'b1, 5'd12, 32'h1212, 1'b0, '0, '0, 5'd12);
        do_reset();
        idle(3, 5'd11);

        // First push after release accepted at the first edge
        step(1'b1, 1'b0, '0, '0, 1'b1, 5'd14, 32'h1414, 5'd14);
        idle(3, 5'd14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
